// File: rtl/shared_net_pkg.sv
// -----------------------------------------------------------------------------
// shared_net_pkg
// Shared types and helpers for the shared-net round-robin arbiter:
//   - arb_state_t : arbiter FSM states (IDLE, OWN, TURN)
//   - cnt_width   : bit width needed to hold a counter value 0..max_val
//   - idx_width   : bit width of a requester index for n requesters
//   - rr_pick     : round-robin search returning {found, idx}
// No ports (package).
// -----------------------------------------------------------------------------
package shared_net_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    // Largest supported requester count and the index width that covers it.
    localparam int unsigned RR_MAX_N = 8;
    localparam int unsigned RR_IDX_W = 3;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 32'd1) ? 32'd1 : $clog2(max_val + 32'd1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : $clog2(n);
    endfunction

    // Walk n candidates starting at ptr, wrapping at n-1 by explicit compare
    // (not bit overflow), and return the first requesting index.
    function automatic logic [RR_IDX_W:0] rr_pick(
        input logic [RR_MAX_N-1:0] req,
        input logic [RR_IDX_W-1:0] ptr,
        input int unsigned         n
    );
        logic                found;
        logic [RR_IDX_W-1:0] idx;
        logic [RR_IDX_W-1:0] cand;
        found = 1'b0;
        idx   = 3'd0;
        cand  = ptr;
        for (int unsigned k = 0; k < RR_MAX_N; k++) begin
            if ((k < n) && !found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
            cand = (cand == 3'(n - 32'd1)) ? 3'd0 : cand + 3'd1;
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/shared_net_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin priority rotate. Finds the first set bit
// of req at or after ptr, wrapping modulo N.
// Ports:
//   req   [N-1:0]  request vector
//   ptr   [IW-1:0] rotation start index (0..N-1)
//   found          at least one request set
//   idx   [IW-1:0] winning index (valid when found=1)
// -----------------------------------------------------------------------------
module rr_picker
    import shared_net_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [RR_IDX_W:0] pick;

    // Widen to the package search width, search, and narrow the result back.
    always_comb begin
        pick  = rr_pick(RR_MAX_N'(req), RR_IDX_W'(ptr), N);
        found = pick[RR_IDX_W];
        idx   = IW'(pick[RR_IDX_W-1:0]);
    end

endmodule

// File: rtl/shared_net_arbiter.sv
// -----------------------------------------------------------------------------
// shared_net_arbiter
// Round-robin owner of one shared tri-state net. Exactly one requester drives
// the net at a time; a forced high-Z turnaround of TURN_CYC cycles separates
// consecutive owners. An owner is preempted after MAX_HOLD cycles only if
// another requester is waiting.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        [N-1:0] level-held requests
//   wdata      [W-1:0] x N per-requester drive data
//   gnt        [N-1:0] registered one-hot grant (or zero)
//   owner_id   index of current owner, valid when bus_oe=1
//   bus_oe     net driven this cycle (== |gnt)
//   bus        shared net: wdata[owner_id] when bus_oe=1, else all-z
//   busy       arbiter not idle
//   preempted  one-cycle pulse when ownership ended by MAX_HOLD expiry
// -----------------------------------------------------------------------------
module shared_net_arbiter
    import shared_net_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 5,
    parameter int MAX_HOLD = 4,
    parameter int TURN_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [W-1:0]          wdata [0:N-1],
    output logic [N-1:0]          gnt,
    output logic [$clog2(N)-1:0]  owner_id,
    output logic                  bus_oe,
    output wire  [W-1:0]          bus,
    output logic                  busy,
    output logic                  preempted
);

    localparam int IW = $clog2(N);
    localparam int HW = cnt_width(MAX_HOLD);
    localparam int TW = cnt_width(TURN_CYC);

    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC);
    localparam logic [N-1:0]  ONE_HOT0  = N'(1);

    arb_state_t     state_q,     state_d;
    logic [N-1:0]   gnt_q,       gnt_d;
    logic [IW-1:0]  owner_id_q,  owner_id_d;
    logic           bus_oe_q,    bus_oe_d;
    logic           busy_q,      busy_d;
    logic           preempted_q, preempted_d;
    logic [IW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [HW-1:0]  hold_cnt_q,  hold_cnt_d;
    logic [TW-1:0]  turn_cnt_q,  turn_cnt_d;

    logic           pick_found;
    logic [IW-1:0]  pick_idx;
    logic           owner_req;
    logic           others_waiting;
    logic [IW-1:0]  next_ptr;

    // Single picker shared by the IDLE and end-of-TURN arbitration points.
    rr_picker #(
        .N  (N),
        .IW (IW)
    ) u_rr_picker (
        .req   (req),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_req      = req[owner_id_q];
    assign others_waiting = |(req & ~gnt_q);
    // Explicit compare so non-power-of-2 N wraps to 0 rather than to N.
    assign next_ptr       = (owner_id_q == LAST_IDX) ? IW'(0) : owner_id_q + IW'(1);

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_id_d  = owner_id_q;
        bus_oe_d    = bus_oe_q;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        turn_cnt_d  = turn_cnt_q;
        preempted_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = OWN;
                    gnt_d      = ONE_HOT0 << pick_idx;
                    owner_id_d = pick_idx;
                    bus_oe_d   = 1'b1;
                    hold_cnt_d = HW'(1);
                end else begin
                    state_d  = IDLE;
                    gnt_d    = {N{1'b0}};
                    bus_oe_d = 1'b0;
                end
            end

            OWN: begin
                // Owner drop is checked first so a simultaneous preempt
                // condition never raises the preempted pulse.
                if (!owner_req) begin
                    state_d    = TURN;
                    gnt_d      = {N{1'b0}};
                    bus_oe_d   = 1'b0;
                    rr_ptr_d   = next_ptr;
                    hold_cnt_d = HW'(0);
                    turn_cnt_d = TW'(1);
                end else if ((hold_cnt_q == HOLD_MAX) && others_waiting) begin
                    state_d     = TURN;
                    gnt_d       = {N{1'b0}};
                    bus_oe_d    = 1'b0;
                    rr_ptr_d    = next_ptr;
                    hold_cnt_d  = HW'(0);
                    turn_cnt_d  = TW'(1);
                    preempted_d = 1'b1;
                end else begin
                    // Saturate so a lone requester can hold indefinitely.
                    hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? HOLD_MAX : hold_cnt_q + HW'(1);
                end
            end

            TURN: begin
                if (turn_cnt_q == TURN_LAST) begin
                    if (pick_found) begin
                        state_d    = OWN;
                        gnt_d      = ONE_HOT0 << pick_idx;
                        owner_id_d = pick_idx;
                        bus_oe_d   = 1'b1;
                        hold_cnt_d = HW'(1);
                        turn_cnt_d = TW'(0);
                    end else begin
                        state_d    = IDLE;
                        gnt_d      = {N{1'b0}};
                        bus_oe_d   = 1'b0;
                        turn_cnt_d = TW'(0);
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + TW'(1);
                end
            end

            default: begin
                state_d    = IDLE;
                gnt_d      = {N{1'b0}};
                bus_oe_d   = 1'b0;
                hold_cnt_d = HW'(0);
                turn_cnt_d = TW'(0);
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops any grant without turnaround.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= {N{1'b0}};
            owner_id_q  <= IW'(0);
            bus_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            preempted_q <= 1'b0;
            rr_ptr_q    <= IW'(0);
            hold_cnt_q  <= HW'(0);
            turn_cnt_q  <= TW'(0);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_id_q  <= owner_id_d;
            bus_oe_q    <= bus_oe_d;
            busy_q      <= busy_d;
            preempted_q <= preempted_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign owner_id  = owner_id_q;
    assign bus_oe    = bus_oe_q;
    assign busy      = busy_q;
    assign preempted = preempted_q;
    assign bus       = bus_oe_q ? wdata[owner_id_q] : {W{1'bz}};

endmodule

// File: tb/tb_shared_net_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_net_arbiter
// Three arbiter instances checked every cycle against an ownership-level
// reference model (owner / cycles held / gap remaining / next start index):
//   a: N=4 W=5 MAX_HOLD=4 TURN_CYC=1
//   b: N=3 W=5 MAX_HOLD=2 TURN_CYC=2
//   c: N=4 W=5 MAX_HOLD=4 TURN_CYC=2 (shares inputs with a)
// -----------------------------------------------------------------------------
module tb_shared_net_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req4;
    logic [2:0] req3;
    logic [4:0] wd4 [0:3];
    logic [4:0] wd3 [0:2];

    logic [3:0] gnt_a, gnt_c;
    logic [2:0] gnt_b;
    logic [1:0] owner_a, owner_b, owner_c;
    logic       oe_a, oe_b, oe_c, busy_a, busy_b, busy_c, pre_a, pre_b, pre_c;
    wire  [4:0] bus_a, bus_b, bus_c;

    shared_net_arbiter #(.N(4), .W(5), .MAX_HOLD(4), .TURN_CYC(1)) u_dut_a (
        .clk(clk), .rst(rst), .req(req4), .wdata(wd4), .gnt(gnt_a), .owner_id(owner_a),
        .bus_oe(oe_a), .bus(bus_a), .busy(busy_a), .preempted(pre_a));

    shared_net_arbiter #(.N(3), .W(5), .MAX_HOLD(2), .TURN_CYC(2)) u_dut_b (
        .clk(clk), .rst(rst), .req(req3), .wdata(wd3), .gnt(gnt_b), .owner_id(owner_b),
        .bus_oe(oe_b), .bus(bus_b), .busy(busy_b), .preempted(pre_b));

    shared_net_arbiter #(.N(4), .W(5), .MAX_HOLD(4), .TURN_CYC(2)) u_dut_c (
        .clk(clk), .rst(rst), .req(req4), .wdata(wd4), .gnt(gnt_c), .owner_id(owner_c),
        .bus_oe(oe_c), .bus(bus_c), .busy(busy_c), .preempted(pre_c));

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance: owner (-1 = none), cycles held,
    // high-Z cycles still to go, index where the next search starts.
    int m_owner [3];
    int m_held  [3];
    int m_gap   [3];
    int m_ptr   [3];
    int m_pre   [3];
    int m_n     [3] = '{4, 3, 4};
    int m_mh    [3] = '{4, 2, 4};
    int m_tc    [3] = '{1, 2, 2};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arbitrate(input int i, input logic [7:0] rv);
        for (int k = 0; k < m_n[i]; k++) begin
            int cand;
            cand = (m_ptr[i] + k) % m_n[i];
            if (m_owner[i] < 0 && rv[cand]) begin
                m_owner[i] = cand;
                m_held[i]  = 1;
            end
        end
    endtask

    task automatic release_owner(input int i);
        m_ptr[i]   = (m_owner[i] + 1) % m_n[i];
        m_owner[i] = -1;
        m_gap[i]   = m_tc[i];
    endtask

    task automatic model_step(input int i, input logic [7:0] rv, input logic r);
        if (r) begin
            m_owner[i] = -1; m_held[i] = 0; m_gap[i] = 0; m_ptr[i] = 0; m_pre[i] = 0;
        end else begin
            m_pre[i] = 0;
            if (m_owner[i] >= 0) begin
                if (!rv[m_owner[i]]) begin
                    release_owner(i);
                end else if (m_held[i] >= m_mh[i] && (rv & ~(8'd1 << m_owner[i])) != 8'd0) begin
                    release_owner(i);
                    m_pre[i] = 1;
                end else if (m_held[i] < m_mh[i]) begin
                    m_held[i]++;
                end
            end else if (m_gap[i] > 0) begin
                m_gap[i]--;
                if (m_gap[i] == 0) arbitrate(i, rv);
            end else begin
                arbitrate(i, rv);
            end
        end
    endtask

    task automatic check_inst(input int i, input logic [7:0] g, input logic oe, input logic [7:0] own,
                              input logic bsy, input logic pr, input logic [7:0] bs, input logic [7:0] eb);
        logic [7:0] eg;
        eg = (m_owner[i] >= 0) ? (8'd1 << m_owner[i]) : 8'd0;
        check($sformatf("gnt_%0d", i), g, eg);
        check($sformatf("bus_oe_%0d", i), {7'd0, oe}, {7'd0, (m_owner[i] >= 0)});
        check($sformatf("busy_%0d", i), {7'd0, bsy}, {7'd0, (m_owner[i] >= 0 || m_gap[i] > 0)});
        check($sformatf("preempted_%0d", i), {7'd0, pr}, 8'(m_pre[i]));
        if (m_owner[i] >= 0) begin
            check($sformatf("owner_id_%0d", i), own, 8'(m_owner[i]));
            check($sformatf("bus_%0d", i), bs, eb);
        end
    endtask

    task automatic step(input bit rand_wd);
        logic [7:0] eb;
        @(posedge clk);
        model_step(0, {4'd0, req4}, rst);
        model_step(1, {5'd0, req3}, rst);
        model_step(2, {4'd0, req4}, rst);
        #1;
        eb = 8'd0;
        if (m_owner[0] >= 0) eb = {3'd0, wd4[m_owner[0]]};
        check_inst(0, {4'd0, gnt_a}, oe_a, {6'd0, owner_a}, busy_a, pre_a, {3'd0, bus_a}, eb);
        eb = 8'd0;
        if (m_owner[1] >= 0) eb = {3'd0, wd3[m_owner[1]]};
        check_inst(1, {5'd0, gnt_b}, oe_b, {6'd0, owner_b}, busy_b, pre_b, {3'd0, bus_b}, eb);
        eb = 8'd0;
        if (m_owner[2] >= 0) eb = {3'd0, wd4[m_owner[2]]};
        check_inst(2, {4'd0, gnt_c}, oe_c, {6'd0, owner_c}, busy_c, pre_c, {3'd0, bus_c}, eb);
        if (rand_wd) begin
            for (int k = 0; k < 4; k++) wd4[k] = 5'($urandom);
            for (int k = 0; k < 3; k++) wd3[k] = 5'($urandom);
        end
    endtask

    task automatic run(input int n, input bit rand_wd);
        for (int k = 0; k < n; k++) step(rand_wd);
    endtask

    initial begin
        rst  = 1'b1;
        req4 = 4'd0;
        req3 = 3'd0;
        for (int k = 0; k < 4; k++) wd4[k] = 5'($urandom);
        for (int k = 0; k < 3; k++) wd3[k] = 5'($urandom);
        for (int k = 0; k < 3; k++) begin
            m_owner[k] = -1; m_held[k] = 0; m_gap[k] = 0; m_ptr[k] = 0; m_pre[k] = 0;
        end

        // Reset state.
        run(2, 1'b1);
        check("reset_gnt", {4'd0, gnt_a}, 8'h00);
        check("reset_busy", {7'd0, busy_a}, 8'h00);

        // Two requesters: owner 0 preempted after 4 cycles, then owner 2.
        rst  = 1'b0;
        req4 = 4'b0101;
        step(1'b1);
        check("t1_first_gnt", {4'd0, gnt_a}, 8'h01);
        run(4, 1'b1);
        check("t1_preempt_pulse", {7'd0, pre_a}, 8'h01);
        check("t1_gap_gnt", {4'd0, gnt_a}, 8'h00);
        step(1'b1);
        check("t1_second_gnt", {4'd0, gnt_a}, 8'h04);
        run(8, 1'b1);

        // Lone requester keeps the bus.
        req4 = 4'b0000;
        run(4, 1'b1);
        req4 = 4'b0010;
        run(20, 1'b1);
        check("t2_lone_gnt", {4'd0, gnt_a}, 8'h02);

        // All four requesting: rotation on both turnaround lengths.
        req4 = 4'b1111;
        run(40, 1'b1);

        // Owner 0 drops after 2 cycles while 3 waits.
        rst  = 1'b1;
        req4 = 4'b0000;
        step(1'b1);
        rst  = 1'b0;
        req4 = 4'b1001;
        run(2, 1'b1);
        req4 = 4'b1000;
        step(1'b1);
        check("t4_no_preempt", {7'd0, pre_a}, 8'h00);
        step(1'b1);
        check("t4_gnt3", {4'd0, gnt_a}, 8'h08);
        req4 = 4'b1111;
        run(16, 1'b1);

        // Reset mid-ownership while owner 2 drives 5'h1A.
        rst  = 1'b1;
        req4 = 4'b0000;
        step(1'b0);
        rst    = 1'b0;
        req4   = 4'b0100;
        wd4[2] = 5'h1A;
        run(3, 1'b0);
        check("t5_bus_1a", {3'd0, bus_a}, 8'h1A);
        rst = 1'b1;
        step(1'b0);
        check("t5_rst_gnt", {4'd0, gnt_a}, 8'h00);
        check("t5_rst_busy", {7'd0, busy_a}, 8'h00);
        rst = 1'b0;
        step(1'b0);
        check("t5_regrant", {4'd0, gnt_a}, 8'h04);

        // N=3 pointer wrap: 100 then 011.
        rst = 1'b1;
        step(1'b1);
        rst  = 1'b0;
        req4 = 4'b0000;
        req3 = 3'b100;
        step(1'b1);
        check("t6_gnt_100", {5'd0, gnt_b}, 8'h04);
        req3 = 3'b011;
        run(3, 1'b1);
        check("t6_gnt_001", {5'd0, gnt_b}, 8'h01);
        run(12, 1'b1);

        // Randomised traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) req4 = 4'($urandom);
            if ($urandom_range(0, 5) == 0) req3 = 3'($urandom);
            rst = ($urandom_range(0, 79) == 0);
            step(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
